sram_port_arbiter: RTL

//  Shares one sram_128_64 array between two requesters (A: lookup side, B: refill side).

---
 rtl/sram_port_arbiter_pkg.sv | 7 +
 rtl/sram_port_arbiter_rr_arbiter2.sv | 20 ++
 rtl/sram_port_arbiter.sv | 76 +++++++
 3 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: shared FSM state and round-robin pointer encodings
package sram_port_arbiter_pkg;
    localparam logic [0:0] SWEEP = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;
    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;
endpackage

// File: rtl/sram_port_arbiter_rr_arbiter2.sv
// sram_port_arbiter_rr_arbiter2: two-way round-robin grant with its own pointer flop
module sram_port_arbiter_rr_arbiter2
    import sram_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic valid_a,
    input  logic valid_b,
    output logic grant_a,
    output logic grant_b
);
    logic ptr;
    assign grant_a = valid_a & (~valid_b | ptr == RR_A);
    assign grant_b = valid_b & (~valid_a | ptr == RR_B);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr <= RR_A;
        else if (grant_a) ptr <= RR_B;
        else if (grant_b) ptr <= RR_A;
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-requester front end for one SRAM array with zero-fill sweep
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ENTRIES = 128,
    parameter int IDX_W   = 7,
    parameter int DATA_W  = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [IDX_W-1:0]  a_index,
    input  logic [DATA_W-1:0] a_wmask,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [IDX_W-1:0]  b_index,
    input  logic [DATA_W-1:0] b_wmask,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,
    input  logic              flush_req,
    output logic              busy,
    output logic              sram_ren,
    output logic              sram_wen,
    output logic [IDX_W-1:0]  sram_index,
    output logic [DATA_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    logic [0:0] state;
    logic [IDX_W:0] sweep_ptr;
    logic sweeping, arb_en, last, ga, gb;
    assign sweeping = state == SWEEP;
    assign busy = sweeping;
    assign arb_en = ~sweeping & ~flush_req;
    assign last = sweep_ptr == (IDX_W+1)'(ENTRIES - 1);
    sram_port_arbiter_rr_arbiter2 u_arb (
        .clk(clk),
        .rstn(rstn),
        .valid_a(a_valid & arb_en),
        .valid_b(b_valid & arb_en),
        .grant_a(ga),
        .grant_b(gb)
    );
    assign a_ready = ga;
    assign b_ready = gb;
    // the array's registered output is the response; no extra flop here
    assign a_rsp_rdata = sram_rdata;
    assign b_rsp_rdata = sram_rdata;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= SWEEP;
            sweep_ptr <= '0;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
        end else begin
            a_rsp_valid <= ga & ~a_we;
            b_rsp_valid <= gb & ~b_we;
            if (sweeping) begin
                sweep_ptr <= last ? '0 : sweep_ptr + 1'b1;
                state <= last ? IDLE : SWEEP;
            end else if (flush_req) state <= SWEEP;
        end
    end
    assign sram_wen = sweeping | (ga & a_we) | (gb & b_we);
    assign sram_ren = (ga & ~a_we) | (gb & ~b_we);
    assign sram_index = sweeping ? sweep_ptr[IDX_W-1:0] : ga ? a_index : gb ? b_index : '0;
    assign sram_wmask = sweeping ? '1 : ga ? a_wmask : gb ? b_wmask : '0;
    assign sram_wdata = sweeping ? '0 : ga ? a_wdata : gb ? b_wdata : '0;
endmodule
